// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin front end that lets NUM_REQ byte sources share
// one uart_tx serializer. Each grant becomes an optional ID byte plus a data
// byte. DV is only issued while the serializer is neither active nor done.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WORD    = 8,
    parameter bit ADD_ID  = 1'b1,
    localparam int GW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    i_Clock,
    input  logic                    i_Rst_n,
    input  logic [NUM_REQ-1:0]      i_Req_Valid,
    input  logic [NUM_REQ*WORD-1:0] i_Req_Data,
    output logic [NUM_REQ-1:0]      o_Req_Ready,
    output logic                    o_Tx_DV,
    output logic [WORD-1:0]         o_Tx_Byte,
    input  logic                    i_Tx_Active,
    input  logic                    i_Tx_Done,
    output logic                    o_Busy,
    output logic [GW-1:0]           o_Grant_Id
);

    typedef enum logic [2:0] {
        IDLE,
        ID_ISSUE,
        ID_WAIT,
        DATA_ISSUE,
        DATA_WAIT
    } state_e;

    state_e            state_q, state_d;
    logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [WORD-1:0]   tx_byte_q, tx_byte_d;
    logic [WORD-1:0]   data_q, data_d;
    logic              done_q;

    logic              lo_found, hi_found, win_valid;
    logic [GW-1:0]     lo_idx, hi_idx, win_idx;
    logic [WORD-1:0]   win_data, id_byte;
    logic [NUM_REQ-1:0] req_ready;
    logic              tx_dv;
    logic              line_free, done_rise;

    // The serializer holds done for several cycles; only its rising edge ends a byte.
    assign line_free = !i_Tx_Active && !i_Tx_Done;
    assign done_rise = i_Tx_Done && !done_q;

    // Round-robin pick: lowest valid index at/above rr_ptr, else lowest valid overall.
    always_comb begin
        lo_found = 1'b0;
        hi_found = 1'b0;
        lo_idx   = '0;
        hi_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (i_Req_Valid[k]) begin
                lo_found = 1'b1;
                lo_idx   = GW'(k);
                if (GW'(k) >= rr_ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = GW'(k);
                end
            end
        end
        win_valid = lo_found;
        win_idx   = hi_found ? hi_idx : lo_idx;
    end

    // Select the winner's data byte and build its ID byte (MSB set, index in low bits).
    always_comb begin
        win_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_idx == GW'(k)) win_data = i_Req_Data[k*WORD +: WORD];
        end
        id_byte            = '0;
        id_byte[WORD-1]    = 1'b1;
        id_byte[GW-1:0]    = win_idx;
    end

    // Next-state and handshake logic for the frame sequencer.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        tx_byte_d = tx_byte_q;
        data_d    = data_q;
        req_ready = '0;
        tx_dv     = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    req_ready[win_idx] = 1'b1;
                    data_d   = win_data;
                    grant_d  = win_idx;
                    // wrap by compare so non-power-of-2 NUM_REQ cycles correctly
                    rr_ptr_d = (win_idx == GW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                    if (ADD_ID) begin
                        tx_byte_d = id_byte;
                        state_d   = ID_ISSUE;
                    end else begin
                        tx_byte_d = win_data;
                        state_d   = DATA_ISSUE;
                    end
                end
            end
            ID_ISSUE: begin
                if (line_free) begin
                    tx_dv   = 1'b1;
                    state_d = ID_WAIT;
                end
            end
            ID_WAIT: begin
                if (done_rise) begin
                    tx_byte_d = data_q;
                    state_d   = DATA_ISSUE;
                end
            end
            DATA_ISSUE: begin
                if (line_free) begin
                    tx_dv   = 1'b1;
                    state_d = DATA_WAIT;
                end
            end
            DATA_WAIT: begin
                if (done_rise) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; the serializer itself is never reset from here.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            tx_byte_q <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            tx_byte_q <= tx_byte_d;
            data_q    <= data_d;
            done_q    <= i_Tx_Done;
        end
    end

    // Ready is masked during reset so nothing is accepted while the block is held.
    assign o_Req_Ready = req_ready & {NUM_REQ{i_Rst_n}};
    assign o_Tx_DV     = tx_dv;
    assign o_Tx_Byte   = tx_byte_q;
    assign o_Busy      = (state_q != IDLE);
    assign o_Grant_Id  = grant_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

- Shares one `uart_tx` serializer between `NUM_REQ` independent byte sources using round-robin arbitration.
- Each granted request becomes one frame on the serial line: an optional ID byte naming the requester, then the requester's data byte.
- The block sits directly in front of `uart_tx`: it drives `i_Tx_DV`/`i_Tx_Byte` and sequences on `o_Tx_Active`/`o_Tx_Done`.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..2^(WORD-1).
- `WORD`, 8: byte width; must equal the serializer's `WORD`.
- `ADD_ID`, 1: 1 = send ID byte before data; 0 = data byte only.
- `i_Clock`  in  1  sole clock.
- `i_Rst_n`  in  1  reset, asynchronous, active-low.
- `i_Req_Valid`  in  NUM_REQ  per-requester valid; held with data until accepted.
- `i_Req_Data`  in  NUM_REQ*WORD  requester k's byte at `[k*WORD +: WORD]`.
- `o_Req_Ready`  out  NUM_REQ  one-hot accept; transfer when valid & ready at a clock edge.
- `o_Tx_DV`  out  1  to serializer `i_Tx_DV`; single-cycle pulse.
- `o_Tx_Byte`  out  WORD  to serializer `i_Tx_Byte`.
- `i_Tx_Active`  in  1  from serializer `o_Tx_Active`.
- `i_Tx_Done`  in  1  from serializer `o_Tx_Done`.
- `o_Busy`  out  1  high whenever the state is not IDLE.
- `o_Grant_Id`  out  GW=max(1,$clog2(NUM_REQ))  index of the current or last granted requester.

## Operation
- **States:** IDLE, ID_ISSUE, ID_WAIT, DATA_ISSUE, DATA_WAIT.
- **Line free:** `i_Tx_Active==0 && i_Tx_Done==0`.
- **IDLE**
  - If any valid: winner = first valid index searching upward from pointer `rr_ptr`, wrapping modulo NUM_REQ.
  - `o_Req_Ready[winner]` = 1, combinational, this cycle only.
  - At the edge: latch data; `o_Grant_Id` <= winner; `rr_ptr` <= (winner+1) mod NUM_REQ.
  - Next state: ID_ISSUE if ADD_ID, else DATA_ISSUE.
  - `o_Req_Ready` is all-zero in every state except IDLE.
- **ID_ISSUE**
  - `o_Tx_Byte` = ID byte: MSB set, winner index zero-extended in the low bits, e.g. 8'h82 for k=2.
  - Wait for line free. In the first free cycle, `o_Tx_DV` = 1 for exactly that cycle; next state ID_WAIT.
- **ID_WAIT**
  - Wait for a `i_Tx_Done` rising edge: registered `done_q==0`, `i_Tx_Done==1`. Then go to DATA_ISSUE.
  - Done held high for several cycles counts once.
- **DATA_ISSUE:** same as ID_ISSUE with `o_Tx_Byte` = latched data; next state DATA_WAIT.
- **DATA_WAIT:** on `i_Tx_Done` rising edge go to IDLE.
- **Line-free gate:** the serializer asserts done for 2 cycles and accepts DV only in its idle state. The gate guarantees DV is never issued while the serializer is active or finishing.
- **Requests during a frame:** ignored until IDLE; valid must stay asserted. Dropping valid before ready is a protocol violation with unspecified outcome, but must not hang the block.
- **`rr_ptr` width:** GW; wrap by compare, not by overflow, so non-power-of-2 NUM_REQ works.
- **Reset (any time):**
  - State IDLE, `rr_ptr`=0, `o_Grant_Id`=0, `o_Tx_Byte`=0, `o_Tx_DV`=0, `o_Busy`=0, `o_Req_Ready`=0, `done_q`=0.
  - The serializer is not reset by this block; the line-free gate ensures a post-reset frame waits out any in-flight transmission.

## Timing
- `o_Tx_DV`, `o_Req_Ready` are combinational from registered state and inputs; all other outputs are registered.
- **Request to first DV:** accept at edge 0; ISSUE state in cycle 1; DV in cycle 1 if the line is free. Minimum latency is 1 cycle.
- **`o_Tx_Byte` stability:** valid from ISSUE entry and unchanged through the following WAIT state.
- **Between bytes:** done rise in cycle t → DATA_ISSUE in t+1. DV is issued in the first cycle the line is free, which is t+2 with the serializer's 2-cycle done.
- **Back-to-back frames:** IDLE for exactly 1 cycle between frames when another valid is pending.
- **Simultaneous valids:** the lowest index at or above `rr_ptr` wins. No requester waits more than NUM_REQ-1 frames.

## Test plan
Benches pair the block with the serializer at NUM_REQ=4, WORD=8, CLKS_PER_BIT=4 unless stated.
1. **Reset:** `i_Rst_n`=0 with all valids high → all outputs 0. Release → `o_Req_Ready`=4'b0001 in the first cycle.
2. **Single request:** valid[2], data 8'h5A, ADD_ID=1.
   - `o_Req_Ready`=4'b0100 for one cycle.
   - DV pulses carry 8'h82 then 8'h5A; serial line shows both frames.
   - `o_Busy` falls after the second done rise; `o_Grant_Id`=2.
3. **All four valid continuously:** grants in order 0,1,2,3,0. Exactly 2 DV pulses per grant. DV is never high while `i_Tx_Active`=1 or `i_Tx_Done`=1.
4. **Fairness:** after a grant to 2, valid[1] and valid[3] both high → 3 then 1.
5. **ADD_ID=0:** valid[0], data 8'hC3 → exactly one DV with 8'hC3. IDLE is reached 1 cycle after the done rise.
6. **Reset in DATA_WAIT while the serializer is mid-byte:** re-request valid[1] → `o_Req_Ready` pulses immediately, but DV stays low until the serializer's done has cleared. No corrupted frame appears on the line.
